// File: rtl/k_energy_band_collector.sv
// Collects one FFT frame of per-bin energies, sums them into equal-width bands
// and emits the band totals as an AXI-Stream burst with tlast on the final band.
module k_energy_band_collector #(
  parameter int IN_WIDTH    = 40,
  parameter int FFT_NUM_PTS = 16,
  parameter int NUM_BANDS   = 4,
  parameter int OUT_WIDTH   = 48
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [IN_WIDTH-1:0]            in_energy,
  input  logic                           in_valid,
  output logic [OUT_WIDTH-1:0]           m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           frame_overrun,
  output logic [$clog2(FFT_NUM_PTS)-1:0] bin_index
);

  localparam int BPB     = FFT_NUM_PTS / NUM_BANDS;
  localparam int BIN_W   = $clog2(FFT_NUM_PTS);
  localparam int BAND_SH = $clog2(BPB);
  localparam int PTR_W   = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

  if (FFT_NUM_PTS < 2 || (FFT_NUM_PTS & (FFT_NUM_PTS - 1)) != 0) begin : g_pts_check
    $error("FFT_NUM_PTS must be a power of 2 and at least 2");
  end
  if (NUM_BANDS < 1 || (NUM_BANDS & (NUM_BANDS - 1)) != 0 || NUM_BANDS > FFT_NUM_PTS) begin : g_band_check
    $error("NUM_BANDS must be a power of 2 dividing FFT_NUM_PTS");
  end
  if (OUT_WIDTH < IN_WIDTH + BAND_SH) begin : g_width_check
    $error("OUT_WIDTH too narrow for IN_WIDTH + log2(FFT_NUM_PTS/NUM_BANDS)");
  end

  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic [BIN_W-1:0]     bin_cnt;
  logic [OUT_WIDTH-1:0] acc [NUM_BANDS];
  logic                 frame_done_q;
  logic [PTR_W-1:0]     cur_band;
  logic                 first_bin;
  logic                 last_bin;
  logic [OUT_WIDTH-1:0] in_ext;

  state_t               state;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     ptr_nxt;
  logic [OUT_WIDTH-1:0] obuf [NUM_BANDS];

  always_comb begin
    cur_band  = PTR_W'(bin_cnt >> BAND_SH);
    first_bin = (bin_cnt & BIN_W'(BPB - 1)) == '0;
    last_bin  = (bin_cnt == BIN_W'(FFT_NUM_PTS - 1));
    in_ext    = OUT_WIDTH'(in_energy);
    ptr_nxt   = ptr + 1'b1;
  end

  // Collect path runs regardless of the output FSM; frame_done_q marks the
  // handover cycle, when acc already holds the final bin of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_cnt      <= '0;
      frame_done_q <= 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) acc[b] <= '0;
    end else begin
      frame_done_q <= in_valid && last_bin;
      if (in_valid) begin
        bin_cnt       <= last_bin ? '0 : bin_cnt + 1'b1;
        acc[cur_band] <= first_bin ? in_ext : acc[cur_band] + in_ext;
      end
    end
  end

  // Output FSM: a frame finishing while a burst is still in flight is dropped,
  // including when the final handshake lands on the handover cycle itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      ptr           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      for (int b = 0; b < NUM_BANDS; b++) obuf[b] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_done_q) begin
            for (int b = 0; b < NUM_BANDS; b++) obuf[b] <= acc[b];
            ptr           <= '0;
            state         <= S_SEND;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= acc[0];
            m_axis_tlast  <= (NUM_BANDS == 1);
          end
        end
        S_SEND: begin
          if (m_axis_tready) begin
            if (ptr == PTR_W'(NUM_BANDS - 1)) begin
              state         <= S_IDLE;
              ptr           <= '0;
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              m_axis_tdata  <= '0;
            end else begin
              ptr          <= ptr_nxt;
              m_axis_tdata <= obuf[ptr_nxt];
              m_axis_tlast <= (ptr_nxt == PTR_W'(NUM_BANDS - 1));
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign frame_overrun = frame_done_q && (state == S_SEND);
  assign bin_index     = bin_cnt;

endmodule

// File: tb/tb_k_energy_band_collector.sv
// Scoreboard bench for k_energy_band_collector: a frame-level model predicts
// band sums and drop decisions; a monitor checks every output handshake.
module tb_k_energy_band_collector;

  localparam int IN_W  = 40;
  localparam int NPTS  = 16;
  localparam int NB    = 4;
  localparam int OUT_W = 48;
  localparam int BPB   = NPTS / NB;
  localparam int EW    = OUT_W + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [IN_W-1:0]   in_energy;
  logic              in_valid;
  logic [OUT_W-1:0]  m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              frame_overrun;
  logic [3:0]        bin_index;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0]     exp_q[$];
  logic [OUT_W-1:0]  rx_log[$];
  int                overrun_seen = 0;

  logic [63:0]       m_bins[$];
  logic [63:0]       m_sums[NB];
  bit                m_handover = 0;
  bit                m_expect_valid = 0;

  bit                stalled = 0;
  logic [EW-1:0]     stall_beat;
  bit                rnd_done;

  k_energy_band_collector #(
    .IN_WIDTH(IN_W), .FFT_NUM_PTS(NPTS), .NUM_BANDS(NB), .OUT_WIDTH(OUT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_energy(in_energy), .in_valid(in_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .frame_overrun(frame_overrun), .bin_index(bin_index)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference model: bins collected per frame, sums computed with plain
  // arithmetic; a finished frame is kept only if no earlier beats are pending.
  always @(negedge clk) begin
    if (rst) begin
      m_bins.delete();
      exp_q.delete();
      m_handover     = 0;
      m_expect_valid = 0;
      check("reset_outputs", {m_axis_tvalid, m_axis_tlast, frame_overrun, bin_index, m_axis_tdata}, 64'd0);
    end else begin
      check("bin_index", {60'd0, bin_index}, 64'(m_bins.size()));
      if (m_expect_valid) begin
        check("tvalid_latency", {63'd0, m_axis_tvalid}, 64'd1);
        m_expect_valid = 0;
      end
      if (m_handover) begin
        m_handover = 0;
        if (exp_q.size() > 0) begin
          check("frame_overrun_drop", {63'd0, frame_overrun}, 64'd1);
        end else begin
          check("frame_overrun_accept", {63'd0, frame_overrun}, 64'd0);
          for (int b = 0; b < NB; b++)
            exp_q.push_back({(b == NB - 1) ? 1'b1 : 1'b0, m_sums[b][OUT_W-1:0]});
          m_expect_valid = 1;
        end
      end else begin
        check("frame_overrun_quiet", {63'd0, frame_overrun}, 64'd0);
      end
      if (frame_overrun) overrun_seen++;
      if (in_valid) begin
        m_bins.push_back(64'(in_energy));
        if (m_bins.size() == NPTS) begin
          for (int b = 0; b < NB; b++) begin
            m_sums[b] = 64'd0;
            for (int k = 0; k < BPB; k++) m_sums[b] += m_bins[b * BPB + k];
          end
          m_bins.delete();
          m_handover = 1;
        end
      end
    end
  end

  // Monitor: pops on each handshake, checks hold-stability during stalls.
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      stalled = 0;
    end else begin
      if (stalled)
        check("stall_hold", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 64'({1'b1, stall_beat}));
      if (m_axis_tvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h, expected no beat", m_axis_tdata);
          stalled = 0;
        end else if (m_axis_tready) begin
          check("beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_q.pop_front()));
          rx_log.push_back(m_axis_tdata);
          stalled = 0;
        end else begin
          stalled    = 1;
          stall_beat = {m_axis_tlast, m_axis_tdata};
        end
      end else begin
        stalled = 0;
      end
    end
  end

  // driver tasks
  task automatic drive_bin(input logic [IN_W-1:0] e);
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_energy = e;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_energy = IN_W'({$urandom(), $urandom()});
  endtask

  // kind: 0 ramp 1..NPTS, 1 constant cval, 2 random; gap: 0 none, 1 alternate, 2 random
  task automatic drive_frame(input int kind, input logic [IN_W-1:0] cval, input int gap);
    for (int i = 0; i < NPTS; i++) begin
      logic [IN_W-1:0] v;
      case (kind)
        0:       v = IN_W'(i + 1);
        1:       v = cval;
        default: v = IN_W'({$urandom(), $urandom()});
      endcase
      drive_bin(v);
      if (gap == 1) idle_cycle();
      else if (gap == 2) repeat ($urandom_range(0, 2)) idle_cycle();
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    repeat (3) idle_cycle();
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending beats, expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_rx(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] c, input logic [63:0] d);
    check({name, "_count"}, 64'(rx_log.size()), 64'd4);
    if (rx_log.size() == 4) begin
      check({name, "_b0"}, 64'(rx_log[0]), a);
      check({name, "_b1"}, 64'(rx_log[1]), b);
      check({name, "_b2"}, 64'(rx_log[2]), c);
      check({name, "_b3"}, 64'(rx_log[3]), d);
    end
  endtask

  initial begin
    int ov0;
    int n;
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_energy     = '0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // ramp frame, continuous, tready high
    m_axis_tready = 1'b1;
    rx_log.delete();
    drive_frame(0, '0, 0);
    wait_drain();
    check_rx("ramp", 64'd10, 64'd26, 64'd42, 64'd58);

    // all-ones frame, no truncation
    rx_log.delete();
    drive_frame(1, 40'hFF_FFFF_FFFF, 0);
    wait_drain();
    check_rx("max", 64'h03_FFFF_FFFF_FC, 64'h03_FFFF_FFFF_FC, 64'h03_FFFF_FFFF_FC, 64'h03_FFFF_FFFF_FC);

    // gapped input, 5-cycle stall on beat 2
    rx_log.delete();
    ov0 = overrun_seen;
    m_axis_tready = 1'b0;
    drive_frame(0, '0, 1);
    n = 0;
    while (!m_axis_tvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_tvalid_seen", {63'd0, m_axis_tvalid}, 64'd1);
    @(posedge clk); #1 m_axis_tready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 m_axis_tready = 1'b0;
    repeat (4) @(posedge clk);
    @(posedge clk); #1 m_axis_tready = 1'b1;
    wait_drain();
    check_rx("stall", 64'd10, 64'd26, 64'd42, 64'd58);
    check("stall_no_overrun", 64'(overrun_seen - ov0), 64'd0);

    // back-to-back frames with blocked output: second frame dropped
    rx_log.delete();
    ov0 = overrun_seen;
    m_axis_tready = 1'b0;
    drive_frame(0, '0, 0);
    drive_frame(1, 40'd2, 0);
    repeat (40) idle_cycle();
    m_axis_tready = 1'b1;
    wait_drain();
    check_rx("overrun", 64'd10, 64'd26, 64'd42, 64'd58);
    check("overrun_pulses", 64'(overrun_seen - ov0), 64'd1);

    // frame B arrives while A drains: both delivered
    rx_log.delete();
    ov0 = overrun_seen;
    drive_frame(0, '0, 0);
    drive_frame(2, '0, 0);
    wait_drain();
    check("two_frames_beats", 64'(rx_log.size()), 64'd8);
    check("two_frames_no_overrun", 64'(overrun_seen - ov0), 64'd0);

    // reset after 7 bins discards the partial frame
    for (int i = 0; i < 7; i++) drive_bin(IN_W'($urandom_range(1, 1000)));
    @(posedge clk); #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("reset_bin_index", {60'd0, bin_index}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    rx_log.delete();
    drive_frame(1, 40'd1, 0);
    wait_drain();
    check_rx("after_reset", 64'd4, 64'd4, 64'd4, 64'd4);

    // randomized frames, gaps and backpressure
    rnd_done = 0;
    fork
      begin
        for (int f = 0; f < 20; f++) drive_frame(2, '0, $urandom_range(0, 2));
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 m_axis_tready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m_axis_tready = 1'b1;
    wait_drain();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
